// File: rtl/onchip_stream_writer_if.sv
// Stream sink plus on-chip RAM write port of the stream writer, as one bundle.
// master = writer side (takes the stream, drives the RAM); slave = stream source and RAM side.
interface onchip_stream_writer_if #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0]   snk_data;
    logic [DATA_W/8-1:0] snk_byteen;
    logic                snk_valid;
    logic                snk_ready;
    logic [ADDR_W-1:0]   mem_address;
    logic [DATA_W/8-1:0] mem_byteenable;
    logic                mem_chipselect;
    logic                mem_write;
    logic [DATA_W-1:0]   mem_writedata;
    logic                mem_clken;

    modport master (
        input  snk_data, snk_byteen, snk_valid,
        output snk_ready,
        output mem_address, mem_byteenable, mem_chipselect, mem_write, mem_writedata, mem_clken
    );

    modport slave (
        output snk_data, snk_byteen, snk_valid,
        input  snk_ready,
        input  mem_address, mem_byteenable, mem_chipselect, mem_write, mem_writedata, mem_clken
    );
endinterface

// File: rtl/onchip_stream_writer.sv
// Generic FIFO with synchronous flush; DEPTH must be a power of two, at least 2.
// Latency: a pushed entry is at the head one cycle later.
// Backpressure: full blocks pushes, empty blocks pops; flush overrides both.
module stream_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         core_clk,
    input  logic         arst_n,
    input  logic         flush,
    input  logic         push_vld,
    input  logic [W-1:0] push_dat,
    input  logic         pop_rdy,
    output logic [W-1:0] pop_dat,
    output logic         empty,
    output logic         full
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] PTR_ONE = 1;

    logic [W-1:0]   mem_q [DEPTH];
    logic [PTR_W:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;

    // Pointers carry one extra wrap bit to tell full from empty.
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign pop_dat = mem_q[rd_ptr_q[PTR_W-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push_vld && !full) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (pop_rdy && !empty) rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge core_clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge core_clk) begin
        if (push_vld && !full && !flush) mem_q[wr_ptr_q[PTR_W-1:0]] <= push_dat;
    end
endmodule

// Writes a programmed number of stream words to consecutive on-chip RAM addresses.
// Latency: a word accepted on edge N is on the mem_* bus during the cycle after edge N.
// Backpressure: snk_ready drops when the FIFO is full or the programmed count has been accepted.
module onchip_stream_writer #(
    parameter int ADDR_W     = 13,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int MEM_WORDS  = 6250
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] word_count,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              error,
    onchip_stream_writer_if.master bus
);
    localparam int BE_W = DATA_W / 8;
    localparam logic [ADDR_W-1:0] ONE = 1;
    localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W + 1)'(MEM_WORDS);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d, cnt_q, cnt_d;
    logic [ADDR_W-1:0] accepted_q, accepted_d, written_q, written_d;
    logic              error_q, error_d, clken_q, clken_d;
    logic              push, pop, flush, last_write;
    logic              fifo_empty, fifo_full;
    logic [BE_W+DATA_W-1:0] fifo_dat;
    logic [ADDR_W:0]   end_addr;

    assign end_addr      = {1'b0, base_addr} + {1'b0, word_count};
    assign bus.snk_ready = (state_q == RUN) && !fifo_full && (accepted_q < cnt_q);
    assign push          = bus.snk_valid && bus.snk_ready;
    assign pop           = (state_q == RUN) && !fifo_empty;
    assign last_write    = pop && ((written_q + ONE) == cnt_q);

    stream_fifo #(.W(BE_W + DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .core_clk (clk),
        .arst_n   (reset_n),
        .flush    (flush),
        .push_vld (push),
        .push_dat ({bus.snk_byteen, bus.snk_data}),
        .pop_rdy  (pop),
        .pop_dat  (fifo_dat),
        .empty    (fifo_empty),
        .full     (fifo_full)
    );

    // The RAM has no waitrequest: a head entry is written in the cycle it is popped.
    assign bus.mem_chipselect = pop;
    assign bus.mem_write      = pop;
    assign bus.mem_address    = pop ? (base_q + written_q) : '0;
    assign bus.mem_writedata  = pop ? fifo_dat[DATA_W-1:0] : '0;
    assign bus.mem_byteenable = pop ? fifo_dat[DATA_W +: BE_W] : '0;
    assign bus.mem_clken      = clken_q;

    assign busy  = (state_q == RUN);
    assign done  = (state_q == FIN);
    assign error = error_q;

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        cnt_d      = cnt_q;
        accepted_d = accepted_q;
        written_d  = written_q;
        error_d    = 1'b0;
        flush      = 1'b0;
        clken_d    = 1'b1;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    base_d = base_addr;
                    cnt_d  = word_count;
                    if (word_count == '0) begin
                        state_d = FIN;
                    end else if (end_addr > MEM_LIMIT) begin
                        error_d = 1'b1;
                    end else begin
                        state_d    = RUN;
                        accepted_d = '0;
                        written_d  = '0;
                    end
                end
            end
            RUN: begin
                if (push) accepted_d = accepted_q + ONE;
                if (pop)  written_d  = written_q + ONE;
                // A final write coinciding with abort still completes as a normal finish.
                if (last_write) begin
                    state_d = FIN;
                end else if (abort) begin
                    state_d = IDLE;
                    error_d = 1'b1;
                    flush   = 1'b1;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            base_q     <= '0;
            cnt_q      <= '0;
            accepted_q <= '0;
            written_q  <= '0;
            error_q    <= 1'b0;
            clken_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            cnt_q      <= cnt_d;
            accepted_q <= accepted_d;
            written_q  <= written_d;
            error_q    <= error_d;
            clken_q    <= clken_d;
        end
    end
endmodule

// File: tb/tb_onchip_stream_writer.sv
// Directed bench for onchip_stream_writer: a negedge monitor logs RAM writes and handshakes,
// scenario tasks drive transfers and compare the log against hand-computed values.
module tb_onchip_stream_writer;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [12:0] base_addr = '0;
    logic [12:0] word_count = '0;
    logic        abort = 1'b0;
    logic        busy, done, error;

    onchip_stream_writer_if bus ();

    onchip_stream_writer dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .base_addr  (base_addr),
        .word_count (word_count),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    int n_asserts = 0;
    int n_fail = 0;
    int cyc = 0;

    logic [12:0] log_addr[$];
    logic [31:0] log_data[$];
    logic [3:0]  log_be[$];
    int          log_cyc[$];
    int          hs_cyc[$];
    int done_cnt = 0, err_cnt = 0, occ = 0, max_occ = 0, bad_ready = 0, exp_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (busy && !bus.snk_ready && occ < DEPTH && hs_cyc.size() < exp_cnt) bad_ready++;
        if (bus.mem_write) begin
            log_addr.push_back(bus.mem_address);
            log_data.push_back(bus.mem_writedata);
            log_be.push_back(bus.mem_byteenable);
            log_cyc.push_back(cyc);
        end
        if (bus.snk_valid && bus.snk_ready) hs_cyc.push_back(cyc);
        if (done)  done_cnt++;
        if (error) err_cnt++;
        occ = occ + int'(bus.snk_valid && bus.snk_ready) - int'(bus.mem_write);
        if (occ > max_occ) max_occ = occ;
    end

    task automatic clear_log();
        log_addr.delete(); log_data.delete(); log_be.delete(); log_cyc.delete(); hs_cyc.delete();
        done_cnt = 0; err_cnt = 0; occ = 0; max_occ = 0; bad_ready = 0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Entered and left at 1ns after a rising edge.
    task automatic do_start(input logic [12:0] b, input logic [12:0] c);
        start = 1'b1; base_addr = b; word_count = c;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Word i carries data first+i and byte enables 4'hF-i; returns right after the last handshake edge.
    task automatic send(input int n, input logic [31:0] first, input bit toggle);
        int i = 0;
        int c = 0;
        bit hs;
        while (i < n && c < 100) begin
            bus.snk_valid  = toggle ? (c % 2 == 0) : 1'b1;
            bus.snk_data   = first + 32'(i);
            bus.snk_byteen = 4'hF - 4'(i);
            @(negedge clk);
            hs = bus.snk_valid && bus.snk_ready;
            @(posedge clk); #1;
            if (hs) i++;
            c++;
        end
        bus.snk_valid = 1'b0;
        if (i < n) begin
            n_asserts++; n_fail++;
            $display("FAIL send_timeout: accepted %0d words, required %0d", i, n);
        end
    endtask

    task automatic test_reset();
        #1;
        n_asserts++;
        if ({busy, done, error, bus.snk_ready, bus.mem_chipselect, bus.mem_write, bus.mem_clken} !== 7'b0) begin
            n_fail++; $display("FAIL reset_ctrl: got %b required 0000000",
                {busy, done, error, bus.snk_ready, bus.mem_chipselect, bus.mem_write, bus.mem_clken});
        end
        n_asserts++;
        if ({bus.mem_address, bus.mem_byteenable, bus.mem_writedata} !== 49'b0) begin
            n_fail++; $display("FAIL reset_bus: got %h required 0",
                {bus.mem_address, bus.mem_byteenable, bus.mem_writedata});
        end
        @(negedge clk); reset_n = 1'b1; #1;
        n_asserts++;
        if (bus.mem_clken !== 1'b0) begin n_fail++; $display("FAIL clken_pre_edge: got %b required 0", bus.mem_clken); end
        @(posedge clk); #1;
        n_asserts++;
        if (bus.mem_clken !== 1'b1) begin n_fail++; $display("FAIL clken_post_edge: got %b required 1", bus.mem_clken); end
    endtask

    task automatic test_basic();
        clear_log();
        do_start(13'h0010, 13'd4);
        send(4, 32'hA0, 1'b0);
        bus.snk_valid = 1'b1; bus.snk_data = 32'hDEAD;
        @(negedge clk);
        n_asserts++;
        if (bus.snk_ready !== 1'b0) begin n_fail++; $display("FAIL basic_ready_drop: got %b required 0", bus.snk_ready); end
        @(posedge clk); #1;
        wait_cycles(4);
        bus.snk_valid = 1'b0;
        n_asserts++;
        if (log_addr.size() != 4 || hs_cyc.size() != 4) begin
            n_fail++; $display("FAIL basic_counts: writes %0d accepts %0d required 4 4", log_addr.size(), hs_cyc.size());
        end
        for (int i = 0; i < 4 && i < log_addr.size() && i < hs_cyc.size(); i++) begin
            n_asserts++;
            if (log_addr[i] !== 13'h10 + 13'(i) || log_data[i] !== 32'hA0 + 32'(i) ||
                log_cyc[i] != log_cyc[0] + i || log_cyc[i] != hs_cyc[i] + 1) begin
                n_fail++; $display("FAIL basic_word[%0d]: addr %h data %h cyc %0d (accepted %0d) required addr %h data %h cyc %0d",
                    i, log_addr[i], log_data[i], log_cyc[i], hs_cyc[i], 13'h10 + 13'(i), 32'hA0 + 32'(i), hs_cyc[i] + 1);
            end
        end
        n_asserts++;
        if (done_cnt != 1) begin n_fail++; $display("FAIL basic_done: got %0d pulses required 1", done_cnt); end
    endtask

    task automatic test_toggle();
        clear_log();
        do_start(13'h0000, 13'd8);
        send(8, 32'h100, 1'b1);
        wait_cycles(4);
        n_asserts++;
        if (log_addr.size() != 8) begin n_fail++; $display("FAIL toggle_count: got %0d writes required 8", log_addr.size()); end
        for (int i = 0; i < 8 && i < log_addr.size(); i++) begin
            n_asserts++;
            if (log_addr[i] !== 13'(i) || log_data[i] !== 32'h100 + 32'(i) || log_be[i] !== 4'hF - 4'(i)) begin
                n_fail++; $display("FAIL toggle_word[%0d]: addr %h data %h be %h required %h %h %h",
                    i, log_addr[i], log_data[i], log_be[i], 13'(i), 32'h100 + 32'(i), 4'hF - 4'(i));
            end
        end
        n_asserts++;
        if (done_cnt != 1) begin n_fail++; $display("FAIL toggle_done: got %0d required 1", done_cnt); end
    endtask

    task automatic test_fifo_full();
        clear_log();
        exp_cnt = 6;
        do_start(13'h0100, 13'd6);
        send(6, 32'h600, 1'b0);
        wait_cycles(4);
        exp_cnt = 0;
        n_asserts++;
        if (max_occ > DEPTH || max_occ < 1) begin n_fail++; $display("FAIL full_occupancy: max %0d required 1..%0d", max_occ, DEPTH); end
        n_asserts++;
        if (bad_ready != 0) begin n_fail++; $display("FAIL full_ready: %0d early deassertions required 0", bad_ready); end
        n_asserts++;
        if (log_addr.size() != 6) begin n_fail++; $display("FAIL full_count: got %0d writes required 6", log_addr.size()); end
        for (int i = 0; i < 6 && i < log_addr.size(); i++) begin
            n_asserts++;
            if (log_addr[i] !== 13'h100 + 13'(i) || log_data[i] !== 32'h600 + 32'(i)) begin
                n_fail++; $display("FAIL full_word[%0d]: addr %h data %h required %h %h",
                    i, log_addr[i], log_data[i], 13'h100 + 13'(i), 32'h600 + 32'(i));
            end
        end
    endtask

    task automatic test_range();
        clear_log();
        do_start(13'd6248, 13'd3);
        @(negedge clk);
        n_asserts++;
        if (error !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL range_err: error %b busy %b required 1 0", error, busy); end
        @(posedge clk); #1;
        bus.snk_valid = 1'b1; bus.snk_data = 32'hBAD;
        wait_cycles(3);
        bus.snk_valid = 1'b0;
        n_asserts++;
        if (log_addr.size() != 0 || hs_cyc.size() != 0 || err_cnt != 1) begin
            n_fail++; $display("FAIL range_quiet: writes %0d accepts %0d errors %0d required 0 0 1",
                log_addr.size(), hs_cyc.size(), err_cnt);
        end
        clear_log();
        do_start(13'd6247, 13'd3);
        send(3, 32'h700, 1'b0);
        wait_cycles(4);
        n_asserts++;
        if (log_addr.size() != 3 || done_cnt != 1 || err_cnt != 0) begin
            n_fail++; $display("FAIL range_edge: writes %0d done %0d errors %0d required 3 1 0",
                log_addr.size(), done_cnt, err_cnt);
        end
        for (int i = 0; i < 3 && i < log_addr.size(); i++) begin
            n_asserts++;
            if (log_addr[i] !== 13'd6247 + 13'(i)) begin
                n_fail++; $display("FAIL range_addr[%0d]: got %0d required %0d", i, log_addr[i], 6247 + i);
            end
        end
    endtask

    task automatic test_zero_and_restart();
        clear_log();
        do_start(13'h0055, 13'd0);
        @(negedge clk);
        n_asserts++;
        if (done !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL zero_done: done %b busy %b required 1 0", done, busy); end
        @(negedge clk);
        n_asserts++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL zero_done_len: done %b required 0", done); end
        @(posedge clk); #1;
        wait_cycles(2);
        n_asserts++;
        if (log_addr.size() != 0 || done_cnt != 1) begin
            n_fail++; $display("FAIL zero_quiet: writes %0d done %0d required 0 1", log_addr.size(), done_cnt);
        end
        clear_log();
        do_start(13'h0020, 13'd2);
        send(1, 32'h800, 1'b0);
        start = 1'b1; base_addr = 13'h0300; word_count = 13'd5;
        @(posedge clk); #1;
        start = 1'b0;
        send(1, 32'h801, 1'b0);
        wait_cycles(4);
        n_asserts++;
        if (log_addr.size() != 2 || done_cnt != 1) begin
            n_fail++; $display("FAIL busy_start_count: writes %0d done %0d required 2 1", log_addr.size(), done_cnt);
        end
        for (int i = 0; i < 2 && i < log_addr.size(); i++) begin
            n_asserts++;
            if (log_addr[i] !== 13'h20 + 13'(i) || log_data[i] !== 32'h800 + 32'(i)) begin
                n_fail++; $display("FAIL busy_start_word[%0d]: addr %h data %h required %h %h",
                    i, log_addr[i], log_data[i], 13'h20 + 13'(i), 32'h800 + 32'(i));
            end
        end
    endtask

    task automatic test_abort();
        clear_log();
        do_start(13'h0040, 13'd5);
        send(2, 32'h900, 1'b0);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        n_asserts++;
        if (error !== 1'b1 || busy !== 1'b0 || bus.mem_write !== 1'b0 || done !== 1'b0) begin
            n_fail++; $display("FAIL abort_next: error %b busy %b write %b done %b required 1 0 0 0",
                error, busy, bus.mem_write, done);
        end
        @(posedge clk); #1;
        bus.snk_valid = 1'b1; bus.snk_data = 32'hBAD;
        wait_cycles(3);
        bus.snk_valid = 1'b0;
        n_asserts++;
        if (log_addr.size() != 2 || hs_cyc.size() != 2 || done_cnt != 0 || err_cnt != 1) begin
            n_fail++; $display("FAIL abort_totals: writes %0d accepts %0d done %0d errors %0d required 2 2 0 1",
                log_addr.size(), hs_cyc.size(), done_cnt, err_cnt);
        end
        clear_log();
        do_start(13'h0060, 13'd1);
        send(1, 32'hA5A5, 1'b0);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        n_asserts++;
        if (done !== 1'b1 || error !== 1'b0) begin n_fail++; $display("FAIL abort_last: done %b error %b required 1 0", done, error); end
        @(posedge clk); #1;
        wait_cycles(2);
        n_asserts++;
        if (log_addr.size() != 1 || err_cnt != 0 || done_cnt != 1) begin
            n_fail++; $display("FAIL abort_last_totals: writes %0d errors %0d done %0d required 1 0 1",
                log_addr.size(), err_cnt, done_cnt);
        end
    endtask

    task automatic test_reset_mid_run();
        clear_log();
        do_start(13'h0050, 13'd4);
        send(1, 32'hB00, 1'b0);
        bus.snk_valid = 1'b1; bus.snk_data = 32'hB01;
        n_asserts++;
        if (bus.mem_write !== 1'b1) begin n_fail++; $display("FAIL midrun_setup: write %b required 1", bus.mem_write); end
        #2 reset_n = 1'b0;
        #1;
        n_asserts++;
        if ({busy, done, error, bus.snk_ready, bus.mem_chipselect, bus.mem_write, bus.mem_clken} !== 7'b0) begin
            n_fail++; $display("FAIL midrun_ctrl: got %b required 0000000",
                {busy, done, error, bus.snk_ready, bus.mem_chipselect, bus.mem_write, bus.mem_clken});
        end
        n_asserts++;
        if ({bus.mem_address, bus.mem_byteenable, bus.mem_writedata} !== 49'b0) begin
            n_fail++; $display("FAIL midrun_bus: got %h required 0",
                {bus.mem_address, bus.mem_byteenable, bus.mem_writedata});
        end
        bus.snk_valid = 1'b0;
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;
        wait_cycles(3);
        n_asserts++;
        if (done_cnt != 0 || err_cnt != 0 || busy !== 1'b0 || bus.mem_clken !== 1'b1) begin
            n_fail++; $display("FAIL midrun_after: done %0d errors %0d busy %b clken %b required 0 0 0 1",
                done_cnt, err_cnt, busy, bus.mem_clken);
        end
    endtask

    initial begin
        bus.snk_valid = 1'b0; bus.snk_data = '0; bus.snk_byteen = '0;
        test_reset();
        test_basic();
        test_toggle();
        test_fifo_full();
        test_range();
        test_zero_and_restart();
        test_abort();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end
endmodule
